// File: rtl/random_pkg.sv
// Shared constants, FSM state encoding and mask helper for the random range users.
package random_pkg;

   localparam int unsigned RND_W = 8;
   localparam logic [RND_W-1:0] LFSR_SEED = 8'h0F;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STEP  = 2'd1,
      CHECK = 2'd2
   } state_t;

   // Sets every bit below the most significant set bit of x.
   function automatic logic [31:0] smear_mask(input logic [31:0] x);
      logic [31:0] m;
      m = x;
      m = m | (m >> 1);
      m = m | (m >> 2);
      m = m | (m >> 4);
      m = m | (m >> 8);
      m = m | (m >> 16);
      return m;
   endfunction

endpackage

// File: rtl/range_mask.sv
// Maps a limit (0 meaning 2^RND_W) to the effective range size and its rejection mask.
module range_mask
   import random_pkg::*;
#(
   parameter int unsigned RND_W = random_pkg::RND_W
) (
   input  logic [RND_W-1:0] limit,
   output logic [RND_W:0]   n_eff_c,
   output logic [RND_W-1:0] mask_c
);

   always_comb begin
      n_eff_c = {limit == '0, limit};
      mask_c  = RND_W'(smear_mask(32'(n_eff_c - (RND_W+1)'(1))));
   end

endmodule

// File: rtl/random_range_sampler.sv
// Unbiased sampler in [0, N) using masked rejection on an external LFSR byte stream,
// with a bounded number of retries before a subtract-once fallback.
module random_range_sampler
   import random_pkg::*;
#(
   parameter int unsigned RND_W     = random_pkg::RND_W,
   parameter int unsigned MAX_TRIES = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req,
   input  logic [RND_W-1:0] limit,
   input  logic [RND_W-1:0] rnd_in,
   output logic             rnd_enable,
   output logic [RND_W-1:0] value,
   output logic             valid,
   output logic             busy,
   output logic             fallback
);

   localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

   state_t           state_q, state_d;
   logic [RND_W:0]   n_eff_q, n_eff_d;
   logic [RND_W-1:0] mask_q, mask_d;
   logic [TRY_W-1:0] tries_q, tries_d;

   logic [RND_W-1:0] value_d;
   logic             valid_d, busy_d, fallback_d, rnd_enable_d;

   logic [RND_W:0]   lim_n_eff_c;
   logic [RND_W-1:0] lim_mask_c;
   logic [RND_W:0]   cand_c;
   logic             last_try_c;

   range_mask #(.RND_W(RND_W)) u_range_mask (
      .limit   (limit),
      .n_eff_c (lim_n_eff_c),
      .mask_c  (lim_mask_c)
   );

   assign cand_c     = {1'b0, rnd_in & mask_q};
   assign last_try_c = (tries_q == TRY_W'(MAX_TRIES - 1));

   // Next-state and next-output logic; rnd_enable is raised on entry to STEP so it is high in STEP.
   always_comb begin
      state_d      = state_q;
      n_eff_d      = n_eff_q;
      mask_d       = mask_q;
      tries_d      = tries_q;
      value_d      = value;
      valid_d      = 1'b0;
      busy_d       = busy;
      fallback_d   = fallback;
      rnd_enable_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (req) begin
               n_eff_d      = lim_n_eff_c;
               mask_d       = lim_mask_c;
               tries_d      = '0;
               busy_d       = 1'b1;
               rnd_enable_d = 1'b1;
               state_d      = STEP;
            end
         end
         STEP: begin
            state_d = CHECK;
         end
         CHECK: begin
            if (cand_c < n_eff_q) begin
               value_d    = RND_W'(cand_c);
               fallback_d = 1'b0;
               valid_d    = 1'b1;
               busy_d     = 1'b0;
               state_d    = IDLE;
            end else if (last_try_c) begin
               // mask < 2*N_eff, so a single subtraction lands inside the range.
               value_d    = RND_W'(cand_c - n_eff_q);
               fallback_d = 1'b1;
               valid_d    = 1'b1;
               busy_d     = 1'b0;
               state_d    = IDLE;
            end else begin
               tries_d      = tries_q + TRY_W'(1);
               rnd_enable_d = 1'b1;
               state_d      = STEP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs; reset is synchronous and active-low.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= IDLE;
         n_eff_q    <= '0;
         mask_q     <= '0;
         tries_q    <= '0;
         value      <= '0;
         valid      <= 1'b0;
         busy       <= 1'b0;
         fallback   <= 1'b0;
         rnd_enable <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_eff_q    <= n_eff_d;
         mask_q     <= mask_d;
         tries_q    <= tries_d;
         value      <= value_d;
         valid      <= valid_d;
         busy       <= busy_d;
         fallback   <= fallback_d;
         rnd_enable <= rnd_enable_d;
      end
   end

endmodule

// File: tb/tb_random_range_sampler.sv
// Scoreboard bench: sampler paired with an 8-bit LFSR generator, checked against a range-sampling model.
module tb_random_range_sampler;

   localparam int unsigned MAX_T = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic       req;
   logic [7:0] limit;
   logic [7:0] rnd_in;
   logic       rnd_enable;
   logic [7:0] value;
   logic       valid;
   logic       busy;
   logic       fallback;

   always #5 clock = ~clock;

   random_range_sampler #(.RND_W(8), .MAX_TRIES(MAX_T)) dut (
      .clock      (clock),
      .reset      (reset),
      .req        (req),
      .limit      (limit),
      .rnd_in     (rnd_in),
      .rnd_enable (rnd_enable),
      .value      (value),
      .valid      (valid),
      .busy       (busy),
      .fallback   (fallback)
   );

   function automatic logic [7:0] lfsr_next(input logic [7:0] r);
      return {r[6:0], ^(r & 8'h8D)};
   endfunction

   // Random byte generator as the parent would instantiate it.
   logic [7:0] gen_q;
   always @(posedge clock) begin
      if (!reset)          gen_q <= 8'h0F;
      else if (rnd_enable) gen_q <= lfsr_next(gen_q);
   end
   assign rnd_in = gen_q;

   typedef struct {
      logic [7:0]  val;
      logic        fb;
      int unsigned at;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        e;
   int          errors = 0;
   int          checks = 0;
   int unsigned cyc = 0;
   logic [7:0]  m_lfsr = 8'h0F;
   int unsigned free_at = 0;
   int unsigned acc_at = 0;
   int unsigned en_exp = 0;
   int unsigned en_seen = 0;
   int unsigned valid_seen = 0;
   logic [7:0]  last_val = '0;
   logic        last_fb = 1'b0;
   bit          mon_on = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // Reference: draw masked candidates from the LFSR sequence until one fits or tries run out.
   task automatic accept(input logic [7:0] lim);
      int unsigned n, p2, mask, cand, k;
      bit          done;
      exp_t        x;
      n    = (lim == 8'd0) ? 256 : int'(lim);
      p2   = 1;
      while (p2 < n) p2 = p2 * 2;
      mask = p2 - 1;
      done = 1'b0;
      k    = 0;
      x.val = '0;
      x.fb  = 1'b0;
      for (int i = 0; i < int'(MAX_T); i++) begin
         if (!done) begin
            m_lfsr = lfsr_next(m_lfsr);
            cand   = int'(m_lfsr) & mask;
            k      = i;
            if (cand < n) begin
               x.val = 8'(cand);
               x.fb  = 1'b0;
               done  = 1'b1;
            end else if (i == int'(MAX_T) - 1) begin
               x.val = 8'(cand - n);
               x.fb  = 1'b1;
               done  = 1'b1;
            end
         end
      end
      x.at    = cyc + 2 + 2 * k;
      en_exp += k + 1;
      acc_at  = cyc;
      free_at = x.at;
      exp_q.push_back(x);
   endtask

   // Monitor: busy window, valid/value/fallback/latency against the scoreboard.
   always @(negedge clock) begin
      if (mon_on) begin
         check("busy", 32'(busy), 32'(cyc >= acc_at && cyc < free_at));
         if (valid) begin
            valid_seen++;
            last_val = value;
            last_fb  = fallback;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid: got valid with value %0h, required no valid (cycle %0d)", value, cyc);
            end else begin
               e = exp_q.pop_front();
               check("value", 32'(value), 32'(e.val));
               check("fallback", 32'(fallback), 32'(e.fb));
               check("latency", cyc, e.at);
            end
         end else if (exp_q.size() != 0 && cyc > exp_q[0].at) begin
            checks++;
            errors++;
            $display("FAIL missing_valid: got none by cycle %0d, required at %0d", cyc, exp_q[0].at);
            void'(exp_q.pop_front());
         end
         if (rnd_enable) en_seen++;
      end
   end

   task automatic step(input logic r, input logic [7:0] lim);
      req   = r;
      limit = lim;
      @(posedge clock);
      #1;
      if (r && cyc >= free_at + 1) accept(lim);
   endtask

   task automatic do_reset(input int n, input bit chk);
      reset = 1'b0;
      req   = 1'b0;
      @(posedge clock);
      #1;
      exp_q.delete();
      m_lfsr  = 8'h0F;
      free_at = cyc;
      acc_at  = cyc;
      en_exp  = 0;
      en_seen = 0;
      if (chk) begin
         #2;
         check("rst_value", 32'(value), 32'h0);
         check("rst_valid", 32'(valid), 32'h0);
         check("rst_busy", 32'(busy), 32'h0);
         check("rst_fallback", 32'(fallback), 32'h0);
         check("rst_rnd_enable", 32'(rnd_enable), 32'h0);
      end
      for (int i = 1; i < n; i++) begin
         @(posedge clock);
         #1;
         free_at = cyc;
         acc_at  = cyc;
      end
      reset  = 1'b1;
      mon_on = 1'b1;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || cyc <= free_at) && n < 100) begin
         step(1'b0, 8'($urandom));
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL timeout: got %0d pending results, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   int unsigned vs;

   initial begin
      reset = 1'b0;
      req   = 1'b0;
      limit = 8'd0;
      do_reset(3, 1'b1);

      // limit 0 (256): first LFSR byte is taken as-is
      step(1'b1, 8'd0);
      wait_done();
      check("t1_value", 32'(last_val), 32'h1F);
      check("t1_fallback", 32'(last_fb), 32'h0);

      do_reset(2, 1'b0);
      step(1'b1, 8'd32);
      wait_done();
      check("t2_value", 32'(last_val), 32'h1F);
      check("t2_fallback", 32'(last_fb), 32'h0);

      // limit 10: four rejections of 15, fallback 15-10
      do_reset(2, 1'b0);
      step(1'b1, 8'd10);
      wait_done();
      check("t3_value", 32'(last_val), 32'h5);
      check("t3_fallback", 32'(last_fb), 32'h1);
      check("t3_enables", en_seen, 32'd4);

      // limit 1 with req held: accepted again in the valid cycle
      do_reset(2, 1'b0);
      vs = valid_seen;
      for (int i = 0; i < 4; i++) step(1'b1, 8'd1);
      wait_done();
      check("t4_valids", valid_seen - vs, 32'd2);
      check("t4_value", 32'(last_val), 32'h0);

      // req while busy is ignored; mid-request limit change has no effect
      do_reset(2, 1'b0);
      vs = valid_seen;
      step(1'b1, 8'd200);
      step(1'b1, 8'd7);
      step(1'b0, 8'd3);
      wait_done();
      check("t5_valids", valid_seen - vs, 32'd1);
      check("t5_value", 32'(last_val), 32'h1F);

      // reset during STEP aborts the request
      do_reset(2, 1'b0);
      step(1'b1, 8'd20);
      vs = valid_seen;
      do_reset(1, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b0, 8'($urandom));
      check("t6_no_valid", valid_seen - vs, 32'd0);

      // randomized traffic with occasional resets
      do_reset(2, 1'b0);
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 149) == 0) do_reset(1, 1'b0);
         else step($urandom_range(0, 2) == 0, 8'($urandom));
      end
      wait_done();
      check("enable_count", en_seen, en_exp);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
